bitmanip_seq: RTL and testbench

BITMANIP_SEQ -- requirements
Module: bitmanip_seq

---
 rtl/bitmanip_seq_if.sv | 48 ++++
 rtl/bitmanip_seq.sv | 139 +++++++++++++
 tb/tb_bitmanip_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bitmanip_seq_if.sv
//==============================================================================
// Module      : bitmanip_seq_if
// Description : Request, bit-manipulation unit and response signals of the
//               bitmanip_seq chain sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface bitmanip_seq_if #(
  parameter int MAX_OPS = 4
);
  localparam int CNT_W = $clog2(MAX_OPS);

  logic                   req_valid;
  logic                   req_ready;
  logic [7:0]             req_operand;
  logic [5*MAX_OPS-1:0]   req_prog;
  logic [CNT_W-1:0]       req_cnt;
  logic [7:0]             bm_operand;
  logic [4:0]             bm_op;
  logic [7:0]             bm_result;
  logic                   bm_z;
  logic                   bm_n;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [7:0]             rsp_result;
  logic                   rsp_z;
  logic                   rsp_n;
  logic                   rsp_err;

  // Sequencer side
  modport slave (
    input  req_valid, req_operand, req_prog, req_cnt,
    input  bm_result, bm_z, bm_n, rsp_ready,
    output req_ready, bm_operand, bm_op,
    output rsp_valid, rsp_result, rsp_z, rsp_n, rsp_err
  );

  // Requester, consumer and bit-manipulation unit side
  modport master (
    output req_valid, req_operand, req_prog, req_cnt,
    output bm_result, bm_z, bm_n, rsp_ready,
    input  req_ready, bm_operand, bm_op,
    input  rsp_valid, rsp_result, rsp_z, rsp_n, rsp_err
  );
endinterface

`default_nettype wire

// File: rtl/bitmanip_seq.sv
//==============================================================================
// Module      : bitmanip_seq
// Description : Runs a chain of up to MAX_OPS bit-manipulation ops through a
//               shared combinational unit. Optional: BMSEQ_ILLEGAL_TRAP_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module bitmanip_seq #(
  parameter int MAX_OPS = 4
) (
  input  wire              clk,
  input  wire              rst_n,
  bitmanip_seq_if.slave    bus
);
  localparam int CNT_W = $clog2(MAX_OPS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t               state_q, state_d;
  logic [7:0]           acc_q, acc_d;
  logic [5*MAX_OPS-1:0] prog_q, prog_d;
  logic [CNT_W-1:0]     step_q, step_d;
  logic [CNT_W-1:0]     last_q, last_d;
  logic                 z_q, z_d;
  logic                 n_q, n_d;
  logic [7:0]           res_q, res_d;
  logic                 rz_q, rz_d;
  logic                 rn_q, rn_d;
  logic                 err_q, err_d;
  logic [4:0]           ops [MAX_OPS];
  logic [4:0]           cur_op;
  logic                 trap;

  for (genvar i = 0; i < MAX_OPS; i++) begin : g_ops
    assign ops[i] = prog_q[5*i +: 5];
  end

  assign cur_op = ops[step_q];

`ifdef BMSEQ_ILLEGAL_TRAP_EN
  assign trap = (cur_op > 5'h13);
`else
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    prog_d  = prog_q;
    step_d  = step_q;
    last_d  = last_q;
    z_d     = z_q;
    n_d     = n_q;
    res_d   = res_q;
    rz_d    = rz_q;
    rn_d    = rn_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          acc_d   = bus.req_operand;
          prog_d  = bus.req_prog;
          last_d  = bus.req_cnt;
          step_d  = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (trap) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          acc_d = bus.bm_result;
          z_d   = bus.bm_z;
          n_d   = bus.bm_n;
          if (step_q == last_q) state_d = DONE;
          else                  step_d  = step_q + CNT_W'(1);
        end
        // Response registers only change when a chain completes, so the
        // last result stays visible while the next chain is running.
        if (state_d == DONE) begin
          res_d = acc_d;
          rz_d  = z_d;
          rn_d  = n_d;
        end
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      prog_q  <= '0;
      step_q  <= '0;
      last_q  <= '0;
      z_q     <= 1'b1;
      n_q     <= 1'b0;
      res_q   <= '0;
      rz_q    <= 1'b1;
      rn_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      prog_q  <= prog_d;
      step_q  <= step_d;
      last_q  <= last_d;
      z_q     <= z_d;
      n_q     <= n_d;
      res_q   <= res_d;
      rz_q    <= rz_d;
      rn_q    <= rn_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.bm_operand = acc_q;
  assign bus.bm_op      = (state_q == RUN) ? cur_op : 5'h1F;
  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_result = res_q;
  assign bus.rsp_z      = rz_q;
  assign bus.rsp_n      = rn_q;
`ifdef BMSEQ_ILLEGAL_TRAP_EN
  assign bus.rsp_err    = err_q;
`else
  assign bus.rsp_err    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bitmanip_seq.sv
//==============================================================================
// Module      : tb_bitmanip_seq
// Description : Directed self-checking bench for bitmanip_seq with a small
//               bit-manipulation unit model (INV 00, INL 01, INH 02, ILB 03,
//               REV 0B, anything else passes the operand through).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_bitmanip_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  bitmanip_seq_if #(.MAX_OPS(4)) bus ();

  bitmanip_seq #(.MAX_OPS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [7:0] bm_model(input logic [7:0] a, input logic [4:0] op);
    logic [7:0] r;
    case (op)
      5'h00: r = ~a;
      5'h01: r = a ^ 8'h0F;
      5'h02: r = a ^ 8'hF0;
      5'h03: r = a ^ 8'h80;
      5'h0B: for (int k = 0; k < 8; k++) r[k] = a[7-k];
      default: r = a;
    endcase
    return r;
  endfunction

  assign bus.bm_result = bm_model(bus.bm_operand, bus.bm_op);
  assign bus.bm_z      = (bus.bm_result == 8'h00);
  assign bus.bm_n      = bus.bm_result[7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // Presents a request, takes the acceptance edge, then scrambles req_*.
  task automatic send(input logic [7:0] opnd, input logic [19:0] prog, input logic [1:0] cnt);
    bus.req_valid   = 1'b1;
    bus.req_operand = opnd;
    bus.req_prog    = prog;
    bus.req_cnt     = cnt;
    chk("send_ready", 32'(bus.req_ready), 32'h1);
    clk1();
    bus.req_valid   = 1'b0;
    bus.req_operand = 8'h33;
    bus.req_prog    = '1;
    bus.req_cnt     = 2'd3;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    clk1();
    bus.rsp_ready = 1'b0;
    chk("hs_valid", 32'(bus.rsp_valid), 32'h0);
    chk("hs_ready", 32'(bus.req_ready), 32'h1);
  endtask

  task automatic chk_rsp(input string tag, input logic [7:0] res, input logic z, input logic n,
                         input logic err);
    chk({tag, "_valid"},  32'(bus.rsp_valid),  32'h1);
    chk({tag, "_result"}, 32'(bus.rsp_result), 32'(res));
    chk({tag, "_z"},      32'(bus.rsp_z),      32'(z));
    chk({tag, "_n"},      32'(bus.rsp_n),      32'(n));
    chk({tag, "_err"},    32'(bus.rsp_err),    32'(err));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"},  32'(bus.req_ready),  32'h1);
    chk({tag, "_valid"},  32'(bus.rsp_valid),  32'h0);
    chk({tag, "_result"}, 32'(bus.rsp_result), 32'h00);
    chk({tag, "_z"},      32'(bus.rsp_z),      32'h1);
    chk({tag, "_n"},      32'(bus.rsp_n),      32'h0);
    chk({tag, "_err"},    32'(bus.rsp_err),    32'h0);
    chk({tag, "_bmop"},   32'(bus.bm_op),      32'h1F);
    chk({tag, "_bmopnd"}, 32'(bus.bm_operand), 32'h00);
  endtask

  initial begin
    bus.req_valid   = 1'b0;
    bus.req_operand = 8'h00;
    bus.req_prog    = '0;
    bus.req_cnt     = 2'd0;
    bus.rsp_ready   = 1'b0;

    // Reset values
    clk1();
    chk_reset_state("rst");
    clk1();
    rst_n = 1'b1;
    clk1();
    chk("rel_ready", 32'(bus.req_ready), 32'h1);

    // A5, INV, single op: result one cycle after acceptance
    send(8'hA5, {5'h1F, 5'h1F, 5'h1F, 5'h00}, 2'd0);
    chk("inv_run_valid", 32'(bus.rsp_valid), 32'h0);
    chk("inv_run_ready", 32'(bus.req_ready), 32'h0);
    chk("inv_bmop",      32'(bus.bm_op),     32'h00);
    chk("inv_bmopnd",    32'(bus.bm_operand), 32'hA5);
    clk1();
    chk_rsp("inv", 8'h5A, 1'b0, 1'b0, 1'b0);
    chk("inv_done_bmop", 32'(bus.bm_op), 32'h1F);
    handshake();

    // 01: REV -> 80, INV -> 7F
    send(8'h01, {5'h1F, 5'h1F, 5'h00, 5'h0B}, 2'd1);
    chk("rev_bmop0",   32'(bus.bm_op),      32'h0B);
    chk("rev_valid0",  32'(bus.rsp_valid),  32'h0);
    chk("rev_retain",  32'(bus.rsp_result), 32'h5A);
    clk1();
    chk("rev_bmop1",   32'(bus.bm_op),      32'h00);
    chk("rev_bmopnd1", 32'(bus.bm_operand), 32'h80);
    chk("rev_valid1",  32'(bus.rsp_valid),  32'h0);
    clk1();
    chk_rsp("revinv", 8'h7F, 1'b0, 1'b0, 1'b0);
    handshake();

    // FF, INV -> 00, zero flag
    send(8'hFF, {5'h1F, 5'h1F, 5'h1F, 5'h00}, 2'd0);
    clk1();
    chk_rsp("zero", 8'h00, 1'b1, 1'b0, 1'b0);
    handshake();

    // 0F: INL -> 00, INH -> F0, INV -> 0F, ILB -> 8F (four ops)
    send(8'h0F, {5'h03, 5'h00, 5'h02, 5'h01}, 2'd3);
    for (int i = 0; i < 3; i++) begin
      chk("four_wait_valid", 32'(bus.rsp_valid), 32'h0);
      clk1();
    end
    chk("four_last_valid", 32'(bus.rsp_valid), 32'h0);
    clk1();
    chk_rsp("four", 8'h8F, 1'b0, 1'b1, 1'b0);

    // Consumer stalls 3 cycles while a new request is presented
    bus.req_valid   = 1'b1;
    bus.req_operand = 8'h3C;
    bus.req_prog    = {5'h1F, 5'h1F, 5'h1F, 5'h00};
    bus.req_cnt     = 2'd0;
    for (int i = 0; i < 3; i++) begin
      clk1();
      chk("stall_valid",  32'(bus.rsp_valid),  32'h1);
      chk("stall_result", 32'(bus.rsp_result), 32'h8F);
      chk("stall_n",      32'(bus.rsp_n),      32'h1);
      chk("stall_ready",  32'(bus.req_ready),  32'h0);
    end
    bus.rsp_ready = 1'b1;
    clk1();
    bus.rsp_ready = 1'b0;
    chk("bubble_ready", 32'(bus.req_ready), 32'h1);
    chk("bubble_valid", 32'(bus.rsp_valid), 32'h0);
    clk1();
    bus.req_valid = 1'b0;
    chk("b2b_run_valid",  32'(bus.rsp_valid),  32'h0);
    chk("b2b_bmopnd",     32'(bus.bm_operand), 32'h3C);
    chk("b2b_retain",     32'(bus.rsp_result), 32'h8F);
    clk1();
    chk_rsp("b2b", 8'hC3, 1'b0, 1'b1, 1'b0);
    handshake();

    // Illegal op 0x15 in the middle: INL -> 00, then trap or pass-through
    send(8'h0F, {5'h1F, 5'h00, 5'h15, 5'h01}, 2'd2);
    clk1();
    chk("ill_bmop1",  32'(bus.bm_op),     32'h15);
    chk("ill_valid1", 32'(bus.rsp_valid), 32'h0);
    clk1();
`ifdef BMSEQ_ILLEGAL_TRAP_EN
    chk_rsp("trap", 8'h00, 1'b1, 1'b0, 1'b1);
`else
    chk("ill_valid2", 32'(bus.rsp_valid), 32'h0);
    chk("ill_bmop2",  32'(bus.bm_op),     32'h00);
    clk1();
    chk_rsp("pass", 8'hFF, 1'b0, 1'b1, 1'b0);
`endif
    handshake();

    // Reset pulse during step 1 of a four-op chain aborts it
    send(8'h55, {5'h00, 5'h00, 5'h00, 5'h00}, 2'd3);
    clk1();
    chk("abort_bmop", 32'(bus.bm_op), 32'h00);
    chk("abort_opnd", 32'(bus.bm_operand), 32'hAA);
    rst_n = 1'b0;
    #1;
    chk_reset_state("abort");
    clk1();
    rst_n = 1'b1;
    clk1();
    chk("abort_rel_ready", 32'(bus.req_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      clk1();
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'h0);
    end
    send(8'hA5, {5'h1F, 5'h1F, 5'h1F, 5'h00}, 2'd0);
    clk1();
    chk_rsp("after_abort", 8'h5A, 1'b0, 1'b0, 1'b0);
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
